// File: rtl/axis_nn_arbiter.sv
// Packet-level round-robin arbiter sharing one axis_nn engine between two
// AXI-Stream requesters; owner IDs are queued so results route back in order.
module axis_nn_arbiter #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned PKT_BEATS     = 7,
  parameter int unsigned ID_FIFO_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [1:0]              s_axis_tvalid,
  input  logic [1:0]              s_axis_tlast,
  output logic [1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic [DATA_WIDTH-1:0]   r_axis_tdata,
  input  logic                    r_axis_tvalid,
  input  logic                    r_axis_tlast,
  output logic                    r_axis_tready,
  output logic [2*DATA_WIDTH-1:0] q_axis_tdata,
  output logic [1:0]              q_axis_tvalid,
  output logic [1:0]              q_axis_tlast,
  input  logic [1:0]              q_axis_tready,
  output logic                    len_err
);

  localparam int unsigned BeatW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int unsigned PtrW  = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_BEATS - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(ID_FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     last_grant_q, last_grant_d;
  logic [BeatW-1:0]         beat_q, beat_d;
  logic                     len_err_q, len_err_d;
  logic [ID_FIFO_DEPTH-1:0] id_mem_q, id_mem_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]          count_q, count_d;

  logic fifo_full, fifo_empty, push, pop, head;
  logic tlast_mis, ownerless;

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  assign head       = id_mem_q[rd_ptr_q];

  // Grant FSM and request-side forwarding
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    beat_d        = beat_q;
    push          = 1'b0;
    tlast_mis     = 1'b0;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = grant_q ? s_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH]
                            : s_axis_tdata[DATA_WIDTH-1:0];
    m_axis_tlast  = (state_q == StBusy) && (beat_q == LastBeat);
    unique case (state_q)
      StIdle: begin
        if ((|s_axis_tvalid) && !fifo_full) begin
          // Both requesting: alternate away from the previous owner
          grant_d = (&s_axis_tvalid) ? ~last_grant_q : s_axis_tvalid[1];
          push    = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
          tlast_mis = (s_axis_tlast[grant_q] != m_axis_tlast);
          if (beat_q == LastBeat) begin
            beat_d       = '0;
            last_grant_d = grant_q;
            state_d      = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result routing to the owner at the head of the ID FIFO
  always_comb begin
    q_axis_tdata  = {2{r_axis_tdata}};
    q_axis_tlast  = {2{r_axis_tlast}};
    q_axis_tvalid = '0;
    r_axis_tready = 1'b0;
    pop           = 1'b0;
    ownerless     = 1'b0;
    if (!fifo_empty) begin
      q_axis_tvalid[head] = r_axis_tvalid;
      r_axis_tready       = q_axis_tready[head];
      pop                 = r_axis_tvalid && q_axis_tready[head] && r_axis_tlast;
    end else begin
      ownerless = r_axis_tvalid;
    end
  end

  // Owner-ID FIFO bookkeeping and sticky error
  always_comb begin
    id_mem_d = id_mem_q;
    if (push) id_mem_d[wr_ptr_q] = grant_d;
    wr_ptr_d  = wr_ptr_q + PtrW'(push);
    rd_ptr_d  = rd_ptr_q + PtrW'(pop);
    count_d   = count_q + CntW'(push) - CntW'(pop);
    len_err_d = len_err_q | tlast_mis | ownerless;
  end

  assign len_err = len_err_q;

  // State registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_q       <= '0;
      len_err_q    <= 1'b0;
      id_mem_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      len_err_q    <= len_err_d;
      id_mem_q     <= id_mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_axis_nn_arbiter.sv
// Randomized bench for axis_nn_arbiter with a packet-level reference model.
module tb_axis_nn_arbiter;

  localparam int DW  = 64;
  localparam int PKT = 7;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [127:0]  s_tdata;
  logic [1:0]    s_tvalid, s_tlast, s_tready;
  logic [63:0]   m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [63:0]   r_tdata;
  logic          r_tvalid, r_tlast, r_tready;
  logic [127:0]  q_tdata;
  logic [1:0]    q_tvalid, q_tlast, q_tready;
  logic          len_err;

  axis_nn_arbiter #(.DATA_WIDTH(DW), .PKT_BEATS(PKT), .ID_FIFO_DEPTH(DEP)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .r_axis_tdata(r_tdata), .r_axis_tvalid(r_tvalid), .r_axis_tlast(r_tlast),
    .r_axis_tready(r_tready),
    .q_axis_tdata(q_tdata), .q_axis_tvalid(q_tvalid), .q_axis_tlast(q_tlast),
    .q_axis_tready(q_tready),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Source state and knobs
  logic [63:0] src_data [2];
  logic        src_v [2];
  logic        src_last [2];
  int          src_beat [2];
  int          src_pkt [2];
  int          budget [2];
  int          vprob [2];
  int          err_beat [2];
  int          mready_mode, rprob, rlast_prob, qprob;
  logic        rand_err, rforce, mt_tog;
  logic [1:0]  hs_s;
  int          pkt_seen;

  // Reference model: packet-level arbiter state and owner queue
  logic        mbusy, mg, mlast_grant, merr;
  int          mbeat;
  logic        mq[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    s_tdata  = {src_data[1], src_data[0]};
    s_tvalid = {src_v[1], src_v[0]};
    s_tlast  = {src_last[1], src_last[0]};
  endtask

  task automatic model_reset();
    mbusy = 1'b0; mg = 1'b0; mlast_grant = 1'b1; merr = 1'b0; mbeat = 0;
    mq.delete();
  endtask

  // Compare DUT outputs against the model, then advance the model one clock
  task automatic check_and_update();
    logic       h;
    logic [1:0] exp_sr, exp_qv;
    logic       exp_rr, pop;
    check_eq("m_tvalid", m_tvalid, mbusy ? src_v[mg] : 1'b0);
    check_eq("m_tlast", m_tlast, mbusy && (mbeat == PKT - 1));
    exp_sr = 2'b00;
    if (mbusy && m_tready) exp_sr[mg] = 1'b1;
    check_eq("s_tready", s_tready, exp_sr);
    if (mbusy) check_eq("m_tdata", m_tdata, src_data[mg]);
    exp_qv = 2'b00; exp_rr = 1'b0; pop = 1'b0; h = 1'b0;
    if (mq.size() > 0) begin
      h = mq[0];
      exp_qv[h] = r_tvalid;
      exp_rr = q_tready[h];
      pop = r_tvalid && q_tready[h] && r_tlast;
    end
    check_eq("q_tvalid", q_tvalid, exp_qv);
    check_eq("r_tready", r_tready, exp_rr);
    if (r_tvalid) begin
      check_eq("q_tdata", q_tdata, {r_tdata, r_tdata});
      check_eq("q_tlast", q_tlast, {r_tlast, r_tlast});
    end
    check_eq("len_err", len_err, merr);
    hs_s = s_tvalid & s_tready;
    if (m_tvalid && m_tready && m_tlast) pkt_seen++;
    if (mq.size() == 0 && r_tvalid) merr = 1'b1;
    if (pop) void'(mq.pop_front());
    if (!mbusy) begin
      if ((src_v[0] || src_v[1]) && (mq.size() + (pop ? 1 : 0)) < DEP) begin
        mg = (src_v[0] && src_v[1]) ? ~mlast_grant : src_v[1];
        mbusy = 1'b1;
        mbeat = 0;
        mq.push_back(mg);
      end
    end else if (src_v[mg] && m_tready) begin
      if (src_last[mg] != (mbeat == PKT - 1)) merr = 1'b1;
      if (mbeat == PKT - 1) begin
        mbusy = 1'b0; mbeat = 0; mlast_grant = mg;
      end else begin
        mbeat++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (hs_s[p]) begin
        src_v[p] = 1'b0;
        if (src_beat[p] == PKT - 1) begin
          src_beat[p] = 0; src_pkt[p]++; budget[p]--;
        end else begin
          src_beat[p]++;
        end
      end
      if (!src_v[p] && budget[p] > 0 && int'($urandom % 100) < vprob[p]) begin
        src_v[p]    = 1'b1;
        src_data[p] = {8'(p), 8'(src_pkt[p]), 8'(src_beat[p]), 8'h00, $urandom()};
        src_last[p] = (err_beat[p] >= 0) ? (src_beat[p] == err_beat[p])
                                         : (src_beat[p] == PKT - 1);
        if (rand_err && ($urandom % 200) == 0) src_last[p] = ~src_last[p];
      end
    end
    drive();
    mt_tog = ~mt_tog;
    case (mready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = mt_tog;
      default: m_tready = 1'($urandom % 2);
    endcase
    r_tvalid = rforce || (mq.size() > 0 && int'($urandom % 100) < rprob);
    r_tdata  = {$urandom(), $urandom()};
    r_tlast  = int'($urandom % 100) < rlast_prob;
    q_tready = {1'(int'($urandom % 100) < qprob), 1'(int'($urandom % 100) < qprob)};
    #1;
    check_and_update();
  endtask

  task automatic do_reset();
    #1 areset = 1'b1;
    #1;
    check_eq("rst_m_tvalid", m_tvalid, 1'b0);
    check_eq("rst_s_tready", s_tready, 2'b00);
    check_eq("rst_r_tready", r_tready, 1'b0);
    check_eq("rst_q_tvalid", q_tvalid, 2'b00);
    check_eq("rst_len_err", len_err, 1'b0);
    model_reset();
    for (int p = 0; p < 2; p++) begin
      src_v[p] = 1'b0; src_beat[p] = 0; src_last[p] = 1'b0; budget[p] = 0;
      err_beat[p] = -1; vprob[p] = 100;
    end
    hs_s = 2'b00; rforce = 1'b0; rand_err = 1'b0; mready_mode = 0;
    rprob = 0; rlast_prob = 100; qprob = 100; pkt_seen = 0;
    drive();
    r_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    logic reached;
    for (int p = 0; p < 2; p++) begin
      src_data[p] = '0; src_pkt[p] = 0;
    end
    mt_tog = 1'b0; m_tready = 1'b1; r_tdata = '0; r_tlast = 1'b0; q_tready = 2'b00;
    do_reset();

    // Port0 alone, one packet, ready always high
    budget[0] = 1;
    repeat (15) step();
    check_eq("p0_pkts", pkt_seen, 1);
    check_eq("p0_no_err", len_err, 1'b0);

    // Both ports saturated, no results: 4 packets then FIFO-full stall
    do_reset();
    budget[0] = 3; budget[1] = 3;
    repeat (60) step();
    check_eq("stall_pkts", pkt_seen, 4);
    rprob = 100; rlast_prob = 100; qprob = 100;
    repeat (60) step();
    check_eq("resume_pkts", pkt_seen, 6);

    // Downstream ready toggling every cycle
    do_reset();
    budget[0] = 2; budget[1] = 2; mready_mode = 1; rprob = 50; rlast_prob = 50; qprob = 60;
    repeat (100) step();
    check_eq("toggle_pkts", pkt_seen, 4);

    // Port1 asserts tlast early on beat 4
    do_reset();
    budget[1] = 1; err_beat[1] = 4;
    repeat (15) step();
    check_eq("early_tlast_err", len_err, 1'b1);
    check_eq("early_tlast_pkts", pkt_seen, 1);

    // Result arriving with no outstanding owner
    do_reset();
    rforce = 1'b1;
    step();
    rforce = 1'b0;
    step();
    check_eq("ownerless_err", len_err, 1'b1);

    // Reset in the middle of a packet
    do_reset();
    budget[0] = 2;
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      step();
      if (mbusy && mbeat == 3) reached = 1'b1;
    end
    check_eq("reach_beat3", reached, 1'b1);
    do_reset();
    budget[0] = 1;
    repeat (15) step();
    check_eq("post_rst_pkts", pkt_seen, 1);

    // Randomized traffic blocks
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      budget[0] = 1000; budget[1] = 1000;
      vprob[0] = 20 + int'($urandom % 80); vprob[1] = 20 + int'($urandom % 80);
      mready_mode = 2; rprob = 50; rlast_prob = 40; qprob = 70; rand_err = 1'b1;
      repeat (400) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
